// File: rtl/periph_bridge.sv
// periph_bridge: decodes the 16 KiB peripheral window, turns a held CPU request
// into single-cycle peripheral strobes, and returns read data or an error
// response to the CPU with a one-cycle ready pulse.
module periph_bridge #(
    parameter logic [31:0] PERIPH_BASE = 32'h0000_4000,
    parameter int unsigned MAX_SLOT    = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    input  logic        cpu_we,
    input  logic        cpu_re,
    output logic [31:0] cpu_rdata,
    output logic        cpu_ready,
    output logic        cpu_err,
    output logic [31:0] err_addr,
    output logic [13:0] per_address,
    output logic [31:0] per_write_data,
    output logic        per_we,
    output logic        per_re,
    input  logic [31:0] per_read_data
);

    localparam int unsigned ADDR_W = 14;
    localparam int unsigned SLOT_W = 5;

    typedef enum logic [2:0] {
        IDLE,
        WR,
        RD_ISSUE,
        RD_CAPT,
        RESP,
        ERR
    } state_t;

    state_t state;
    state_t state_d;

    logic [SLOT_W-1:0] slot;
    logic              hit;
    logic              bad;

    logic [31:0]       cpu_rdata_d;
    logic              cpu_ready_d;
    logic              cpu_err_d;
    logic [31:0]       err_addr_d;
    logic [ADDR_W-1:0] per_address_d;
    logic [31:0]       per_write_data_d;
    logic              per_we_d;
    logic              per_re_d;

    // Window decode and malformed-access classification of the live request.
    always_comb begin
        slot = cpu_addr[12:8];
        hit  = (cpu_we | cpu_re) && (cpu_addr[31:14] == PERIPH_BASE[31:14]);
        bad  = (cpu_addr[1:0] != 2'b00)
            || cpu_addr[13]
            || (slot == '0)
            || (32'(slot) > MAX_SLOT)
            || (cpu_we && cpu_re);
    end

    // Next state and next output values; outputs are registered from these so
    // that each strobe/response appears in the cycle its state is entered.
    // The request is only sampled in IDLE, so the output registers double as
    // the transaction latch and later input changes have no effect.
    always_comb begin
        state_d          = state;
        cpu_rdata_d      = cpu_rdata;
        cpu_ready_d      = 1'b0;
        cpu_err_d        = 1'b0;
        err_addr_d       = err_addr;
        per_address_d    = '0;
        per_write_data_d = '0;
        per_we_d         = 1'b0;
        per_re_d         = 1'b0;

        case (state)
            IDLE: begin
                if (hit) begin
                    if (bad) begin
                        state_d     = ERR;
                        cpu_ready_d = 1'b1;
                        cpu_err_d   = 1'b1;
                        err_addr_d  = cpu_addr;
                        cpu_rdata_d = '0;
                    end else if (cpu_we) begin
                        state_d          = WR;
                        per_we_d         = 1'b1;
                        per_address_d    = cpu_addr[ADDR_W-1:0];
                        per_write_data_d = cpu_wdata;
                    end else begin
                        state_d       = RD_ISSUE;
                        per_re_d      = 1'b1;
                        per_address_d = cpu_addr[ADDR_W-1:0];
                    end
                end
            end
            WR: begin
                state_d     = RESP;
                cpu_ready_d = 1'b1;
            end
            RD_ISSUE: begin
                state_d = RD_CAPT;
            end
            RD_CAPT: begin
                state_d     = RESP;
                cpu_ready_d = 1'b1;
                cpu_rdata_d = per_read_data;
            end
            RESP: begin
                state_d = IDLE;
            end
            ERR: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers; reset drops any in-flight strobe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            cpu_rdata      <= '0;
            cpu_ready      <= 1'b0;
            cpu_err        <= 1'b0;
            err_addr       <= '0;
            per_address    <= '0;
            per_write_data <= '0;
            per_we         <= 1'b0;
            per_re         <= 1'b0;
        end else begin
            state          <= state_d;
            cpu_rdata      <= cpu_rdata_d;
            cpu_ready      <= cpu_ready_d;
            cpu_err        <= cpu_err_d;
            err_addr       <= err_addr_d;
            per_address    <= per_address_d;
            per_write_data <= per_write_data_d;
            per_we         <= per_we_d;
            per_re         <= per_re_d;
        end
    end

endmodule

// File: tb/tb_periph_bridge.sv
// Scoreboard bench for periph_bridge: the driver pushes expected responses and
// strobes; a negedge monitor pops and compares whenever the DUT presents them.
module tb_periph_bridge;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] cpu_addr = '0;
    logic [31:0] cpu_wdata = '0;
    logic        cpu_we = 1'b0;
    logic        cpu_re = 1'b0;
    logic [31:0] cpu_rdata;
    logic        cpu_ready;
    logic        cpu_err;
    logic [31:0] err_addr;
    logic [13:0] per_address;
    logic [31:0] per_write_data;
    logic        per_we;
    logic        per_re;
    logic [31:0] per_read_data = '0;

    periph_bridge dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .cpu_addr       (cpu_addr),
        .cpu_wdata      (cpu_wdata),
        .cpu_we         (cpu_we),
        .cpu_re         (cpu_re),
        .cpu_rdata      (cpu_rdata),
        .cpu_ready      (cpu_ready),
        .cpu_err        (cpu_err),
        .err_addr       (err_addr),
        .per_address    (per_address),
        .per_write_data (per_write_data),
        .per_we         (per_we),
        .per_re         (per_re),
        .per_read_data  (per_read_data)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          cyc;
        logic        err;
        logic [31:0] rdata;
        logic [31:0] eaddr;
    } resp_t;

    typedef struct {
        int          cyc;
        logic        we;
        logic        re;
        logic [13:0] addr;
        logic [31:0] wdata;
    } strobe_t;

    resp_t   resp_q[$];
    strobe_t strobe_q[$];

    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;
    int          ready_cnt = 0;
    int          strobe_cnt = 0;
    logic [31:0] bus_val = '0;
    logic [31:0] last_rd = '0;
    logic [31:0] last_ea = '0;

    // Edge counter: at a negedge, cyc is the number of the edge just passed.
    always @(posedge clk) cyc <= cyc + 1;

    // Peripheral bus model: read data registered one cycle after per_re,
    // poisoned otherwise so a mistimed capture is visible.
    always @(posedge clk) per_read_data <= per_re ? bus_val : 32'hBAD0_BAD0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (edge %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: compare every ready pulse and every strobe against the queues.
    always @(negedge clk) begin
        if (cpu_ready) begin
            ready_cnt++;
            if (resp_q.size() == 0) begin
                chk("unexpected_ready", 32'(cpu_ready), 32'd0);
            end else begin
                resp_t r;
                r = resp_q.pop_front();
                chk("ready_cycle", 32'(cyc), 32'(r.cyc));
                chk("cpu_err", 32'(cpu_err), 32'(r.err));
                chk("cpu_rdata", cpu_rdata, r.rdata);
                chk("err_addr", err_addr, r.eaddr);
            end
        end
        if (per_we || per_re) begin
            strobe_cnt++;
            chk("strobe_exclusive", 32'(per_we & per_re), 32'd0);
            if (strobe_q.size() == 0) begin
                chk("unexpected_strobe", 32'({per_we, per_re}), 32'd0);
            end else begin
                strobe_t s;
                s = strobe_q.pop_front();
                chk("strobe_cycle", 32'(cyc), 32'(s.cyc));
                chk("per_we", 32'(per_we), 32'(s.we));
                chk("per_re", 32'(per_re), 32'(s.re));
                chk("per_address", 32'(per_address), 32'(s.addr));
                chk("per_write_data", per_write_data, s.wdata);
            end
        end else begin
            chk("idle_address", 32'(per_address), 32'd0);
            chk("idle_write_data", per_write_data, 32'd0);
        end
    end

    // Queue the expected outcome of an access sampled at edge e.
    task automatic push_exp(input int e, input logic we, input logic re,
                            input logic [31:0] addr, input logic [31:0] wdata,
                            input logic exp_err);
        resp_t   r;
        strobe_t s;
        if (exp_err) begin
            last_rd = '0;
            last_ea = addr;
            r = '{cyc: e, err: 1'b1, rdata: 32'h0, eaddr: addr};
        end else begin
            if (re) last_rd = bus_val;
            r = '{cyc: (we ? e + 1 : e + 2), err: 1'b0, rdata: last_rd, eaddr: last_ea};
            s = '{cyc: e, we: we, re: re, addr: addr[13:0], wdata: (we ? wdata : 32'h0)};
            strobe_q.push_back(s);
        end
        resp_q.push_back(r);
    endtask

    // Issue one access; reps>1 keeps the request held past ready so it repeats.
    task automatic access(input logic we, input logic re, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic exp_err, input int reps);
        @(posedge clk);
        #1;
        cpu_we    = we;
        cpu_re    = re;
        cpu_addr  = addr;
        cpu_wdata = wdata;
        push_exp(cyc + 1, we, re, addr, wdata, exp_err);
        for (int r = 0; r < reps; r++) begin
            int n;
            n = 0;
            do begin
                @(negedge clk);
                n++;
            end while (!cpu_ready && n < 20);
            if (!cpu_ready) begin
                chk("ready_timeout", 32'(cpu_ready), 32'd1);
                cpu_we = 1'b0;
                cpu_re = 1'b0;
                return;
            end
            if (r < reps - 1) push_exp(cyc + 2, we, re, addr, wdata, exp_err);
        end
        cpu_we = 1'b0;
        cpu_re = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_per_we"}, 32'(per_we), 32'd0);
        chk({tag, "_per_re"}, 32'(per_re), 32'd0);
        chk({tag, "_per_address"}, 32'(per_address), 32'd0);
        chk({tag, "_per_write_data"}, per_write_data, 32'd0);
        chk({tag, "_cpu_ready"}, 32'(cpu_ready), 32'd0);
        chk({tag, "_cpu_err"}, 32'(cpu_err), 32'd0);
        chk({tag, "_cpu_rdata"}, cpu_rdata, 32'd0);
        chk({tag, "_err_addr"}, err_addr, 32'd0);
    endtask

    initial begin
        int r0;
        int s0;

        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Valid write and read.
        access(1'b1, 1'b0, 32'h0000_4104, 32'hDEAD_BEEF, 1'b0, 1);
        bus_val = 32'h1234_5678;
        access(1'b0, 1'b1, 32'h0000_4300, 32'h0, 1'b0, 1);
        access(1'b1, 1'b0, 32'h0000_4204, 32'hA5A5_0001, 1'b0, 1);
        bus_val = 32'hCAFE_F00D;
        access(1'b0, 1'b1, 32'h0000_48FC, 32'h0, 1'b0, 1);

        // Malformed accesses.
        access(1'b0, 1'b1, 32'h0000_4102, 32'h0, 1'b1, 1);
        access(1'b1, 1'b0, 32'h0000_4004, 32'h1111_1111, 1'b1, 1);
        access(1'b0, 1'b1, 32'h0000_4904, 32'h0, 1'b1, 1);
        access(1'b1, 1'b1, 32'h0000_4100, 32'h2222_2222, 1'b1, 1);
        access(1'b0, 1'b1, 32'h0000_6104, 32'h0, 1'b1, 1);

        // Out-of-window request is ignored for 10 cycles.
        @(posedge clk);
        #1;
        r0 = ready_cnt;
        s0 = strobe_cnt;
        cpu_we    = 1'b1;
        cpu_addr  = 32'h0000_0100;
        cpu_wdata = 32'h3333_3333;
        repeat (10) @(posedge clk);
        #1;
        cpu_we = 1'b0;
        chk("oow_ready_count", 32'(ready_cnt - r0), 32'd0);
        chk("oow_strobe_count", 32'(strobe_cnt - s0), 32'd0);

        // Request held past ready repeats the read.
        bus_val = 32'h0BAD_CAFE;
        s0 = strobe_cnt;
        access(1'b0, 1'b1, 32'h0000_4300, 32'h0, 1'b0, 2);
        chk("held_re_pulses", 32'(strobe_cnt - s0), 32'd2);

        // Reset while in RD_ISSUE.
        @(posedge clk);
        #1;
        cpu_re   = 1'b1;
        cpu_addr = 32'h0000_4300;
        @(posedge clk);
        #1;
        chk("pre_reset_per_re", 32'(per_re), 32'd1);
        strobe_cnt++;
        rst_n = 1'b0;
        #1;
        check_all_zero("midreset");
        cpu_re = 1'b0;
        last_rd = '0;
        last_ea = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        bus_val = 32'h55AA_33CC;
        access(1'b0, 1'b1, 32'h0000_4204, 32'h0, 1'b0, 1);

        repeat (5) @(posedge clk);
        #1;
        chk("resp_q_drained", 32'(resp_q.size()), 32'd0);
        chk("strobe_q_drained", 32'(strobe_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Hard time bound so the run always terminates.
    initial begin
        #200000;
        $display("FAIL global_timeout: got edge %0d expected completion", cyc);
        $fatal(1);
    end

endmodule
